// File: rtl/exponential_unit_if.sv
// Start/done handshake bundle for the fixed-point e^x evaluator.
interface exponential_unit_if;
  logic        start;
  logic [15:0] x;
  logic        done;
  logic [1:0]  intpart;
  logic [15:0] fracpart;

  modport master (output start, x, input done, intpart, fracpart);
  modport slave  (input start, x, output done, intpart, fracpart);
endinterface

// File: rtl/exponential_unit.sv
// Sequential e^x for x in [0,1): 8-term Taylor series evaluated by Horner,
// one term per clock, result in Q2.16.
module exponential_unit (
  input  logic              clk,
  input  logic              rst,
  exponential_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] xr_q, xr_d;
  logic [17:0] acc_q, acc_d;
  logic [17:0] res_q, res_d;
  logic [3:0]  k_q, k_d;

  logic [16:0] coef;
  logic [17:0] p, q, acc_iter;

  // round(65536/k) in Q1.16
  always_comb begin
    case (k_q)
      4'd1:    coef = 17'd65536;
      4'd2:    coef = 17'd32768;
      4'd3:    coef = 17'd21845;
      4'd4:    coef = 17'd16384;
      4'd5:    coef = 17'd13107;
      4'd6:    coef = 17'd10923;
      4'd7:    coef = 17'd9362;
      4'd8:    coef = 17'd8192;
      default: coef = 17'd0;
    endcase
  end

  // Horner step: acc <- 1 + (acc*x)/k, both products truncated
  always_comb begin
    p        = 18'(({16'd0, acc_q} * {18'd0, xr_q}) >> 16);
    q        = 18'(({17'd0, p} * {18'd0, coef}) >> 16);
    acc_iter = 18'd65536 + q;
  end

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    acc_d   = acc_q;
    k_d     = k_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CALC;
        xr_d    = bus.x;
        acc_d   = 18'd65536;
        k_d     = 4'd8;
      end
      CALC: begin
        acc_d = acc_iter;
        k_d   = k_q - 4'd1;
        // the last term lands directly in the result register
        if (k_q <= 4'd1) begin
          state_d = DONE;
          res_d   = acc_iter;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      k_q     <= k_d;
    end
  end

  assign bus.done     = (state_q == DONE);
  assign bus.intpart  = res_q[17:16];
  assign bus.fracpart = res_q[15:0];
endmodule

// File: tb/tb_exponential_unit.sv
// Randomized self-checking bench for exponential_unit against a series model.
module tb_exponential_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  exponential_unit_if bus();
  exponential_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Truncated Taylor series 1 + x(1 + x/2(1 + ...)) in integer LSB units.
  function automatic longint model(input longint xv);
    longint acc, c;
    acc = 65536;
    for (int k = 8; k >= 1; k--) begin
      c   = longint'($rtoi(65536.0 / k + 0.5));
      acc = 65536 + ((((acc * xv) >> 16) * c) >> 16);
    end
    return acc;
  endfunction

  // Issues one start pulse and returns the edge count to done (-1 on timeout).
  task automatic do_run(input logic [15:0] xv, input bit scramble,
                        output int lat, output logic [17:0] r);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xv;
    lat       = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 0) bus.start = 1'b0;
      if (scramble && c > 0) bus.x = 16'($urandom);
      if (bus.done) begin lat = c; break; end
    end
    r = {bus.intpart, bus.fracpart};
  endtask

  task automatic test_reset;
    int lat; logic [17:0] r;
    rst = 1'b0; bus.start = 1'b0; bus.x = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_chk++; if (bus.intpart !== 2'd0) begin n_fail++; $display("FAIL reset_int: got %0d want 0", bus.intpart); end
    n_chk++; if (bus.fracpart !== 16'd0) begin n_fail++; $display("FAIL reset_frac: got %0d want 0", bus.fracpart); end
    @(negedge clk); rst = 1'b1;
    do_run(16'd10, 1'b0, lat, r);
    n_chk++; if (lat !== 8) begin n_fail++; $display("FAIL x10_latency: got %0d want 8", lat); end
    n_chk++; if (r[17:16] !== 2'd1) begin n_fail++; $display("FAIL x10_int: got %0d want 1", r[17:16]); end
    n_chk++; if (r[15:0] !== 16'd10) begin n_fail++; $display("FAIL x10_frac: got %0d want 10", r[15:0]); end
    @(posedge clk); #1;
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL x10_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_zero;
    int lat, ndone; logic [17:0] r;
    do_run(16'd0, 1'b0, lat, r);
    n_chk++; if (r !== 18'd65536) begin n_fail++; $display("FAIL zero_result: got %0d want 65536", r); end
    ndone = (lat >= 0) ? 1 : 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    n_chk++; if (ndone !== 1) begin n_fail++; $display("FAIL zero_pulses: got %0d want 1", ndone); end
  endtask

  task automatic test_half;
    int lat; logic [17:0] r;
    do_run(16'h8000, 1'b0, lat, r);
    n_chk++; if (r[17:16] !== 2'd1) begin n_fail++; $display("FAIL half_int: got %0d want 1", r[17:16]); end
    n_chk++;
    if (r[15:0] < 16'd42498 || r[15:0] > 16'd42514) begin
      n_fail++; $display("FAIL half_frac: got %0d want 42498..42514", r[15:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_scramble;
    int lat; logic [17:0] r;
    do_run(16'hFFFF, 1'b1, lat, r);
    n_chk++; if (r[17:16] !== 2'd2) begin n_fail++; $display("FAIL max_int: got %0d want 2", r[17:16]); end
    n_chk++;
    if (r[15:0] < 16'd47057 || r[15:0] > 16'd47073) begin
      n_fail++; $display("FAIL max_frac: got %0d want 47057..47073", r[15:0]);
    end
    n_chk++; if (r !== 18'(model(64'hFFFF))) begin n_fail++; $display("FAIL max_model: got %0d want %0d", r, model(64'hFFFF)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat; logic [17:0] r; logic [15:0] xv; real e;
    for (int i = 0; i < 16; i++) begin
      xv = 16'($urandom);
      do_run(xv, 1'b0, lat, r);
      e = $exp(real'(xv) / 65536.0) * 65536.0;
      n_chk++; if (lat !== 8) begin n_fail++; $display("FAIL rand_latency x=%0d: got %0d want 8", xv, lat); end
      n_chk++; if (r !== 18'(model(longint'(xv)))) begin n_fail++; $display("FAIL rand_model x=%0d: got %0d want %0d", xv, r, model(longint'(xv))); end
      // small slack above covers real-arithmetic rounding of the reference
      n_chk++;
      if (real'(r) > e + 0.01 || real'(r) < e - 16.0) begin
        n_fail++; $display("FAIL rand_accuracy x=%0d: got %0d want within 16 below %f", xv, r, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int last, ndone; logic [17:0] prev; bit have; logic [15:0] xv;
    last = -1; ndone = 0; have = 1'b0; prev = '0;
    xv = 16'($urandom);
    @(negedge clk); bus.x = xv; bus.start = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (last >= 0) begin
          n_chk++; if (c - last !== 10) begin n_fail++; $display("FAIL b2b_interval: got %0d want 10", c - last); end
        end
        n_chk++;
        if ({bus.intpart, bus.fracpart} !== 18'(model(longint'(xv)))) begin
          n_fail++; $display("FAIL b2b_result: got %0d want %0d", {bus.intpart, bus.fracpart}, model(longint'(xv)));
        end
        last = c; ndone++; prev = {bus.intpart, bus.fracpart}; have = 1'b1;
      end else if (have) begin
        n_chk++;
        if ({bus.intpart, bus.fracpart} !== prev) begin
          n_fail++; $display("FAIL b2b_stable: got %0d want %0d", {bus.intpart, bus.fracpart}, prev);
        end
      end
    end
    n_chk++; if (ndone !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", ndone); end
    @(negedge clk); bus.start = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic test_abort;
    int ndone, lat; logic [17:0] r;
    @(negedge clk); bus.x = 16'h4000; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", bus.done); end
    n_chk++;
    if ({bus.intpart, bus.fracpart} !== 18'd0) begin
      n_fail++; $display("FAIL abort_clear: got %0d want 0", {bus.intpart, bus.fracpart});
    end
    @(negedge clk); rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    n_chk++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
    do_run(16'h4000, 1'b0, lat, r);
    n_chk++; if (r !== 18'(model(64'h4000))) begin n_fail++; $display("FAIL post_abort: got %0d want %0d", r, model(64'h4000)); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_half();
    test_max_scramble();
    test_random();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
